// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction fetch stage with a small prefetch queue.
//
// Walks word addresses from RESET_ADDR and keeps at most one request
// outstanding to instruction memory. Returned words are queued together
// with their addresses in a DEPTH-entry FIFO that the core drains through
// inst_valid/inst_ready. A one-cycle redirect pulse flushes the queue and
// restarts fetch at redirect_addr. A request that is in flight when the
// redirect arrives still has to be acked, but its data is thrown away.
//
// Optional feature macro: RISCV_FETCH_BYPASS_EN
//   When defined, a word acked while the queue is empty is presented to the
//   core combinationally in the ack cycle. If the core takes it in that
//   cycle, the word is never written to the queue.
//   When undefined, the core only ever sees queue registers, so a word
//   becomes visible one cycle after its ack.

module riscv_fetch #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,

    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    input  logic        inst_ready,

    input  logic        redirect,
    input  logic [31:0] redirect_addr
);

    // Pointer width covers DEPTH entries. The count needs one extra bit so
    // it can hold the value DEPTH itself.
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [31:0]   fpc;
    logic [31:0]   fpc_next;
    logic          imem_req_next;
    logic [31:0]   imem_addr_next;

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic [31:0]   data_q [DEPTH];
    logic [31:0]   addr_q [DEPTH];

    logic          head_valid;
    logic          ack_live;
    logic          bypass_hit;
    logic          bypass_take;
    logic          fifo_wr;
    logic          fifo_rd;

    // Work out this cycle's queue traffic. The incoming word counts only
    // when the ack belongs to a live request and no redirect is flushing the
    // queue. A redirect also cancels any pop that happens in the same cycle.
    always_comb begin
        head_valid  = (count != '0);
        ack_live    = (state == ST_WAIT) && imem_ack && !redirect;
`ifdef RISCV_FETCH_BYPASS_EN
        bypass_hit  = ack_live && !head_valid;
        bypass_take = bypass_hit && inst_ready;
`else
        bypass_hit  = 1'b0;
        bypass_take = 1'b0;
`endif
        fifo_wr     = ack_live && !bypass_take;
        fifo_rd     = head_valid && inst_ready && !redirect;
        count_next  = count + CW'(fifo_wr) - CW'(fifo_rd);
    end

    // Drive the core-facing head. Queued words always take priority. The
    // live memory word is shown only when the queue is empty and the bypass
    // is active.
    always_comb begin
        inst_valid = head_valid || bypass_hit;
        if (head_valid || !bypass_hit) begin
            inst      = data_q[rd_ptr];
            inst_addr = addr_q[rd_ptr];
        end else begin
            inst      = imem_rdata;
            inst_addr = imem_addr;
        end
    end

    // Next state for the request FSM and the fetch pointer. A new request is
    // issued only when the queue is certain to have room for the reply, so
    // the queue can never overflow. When a redirect arrives, a request that
    // is still in flight is tracked to completion in DROP so its ack is not
    // mistaken for the first new word.
    always_comb begin
        state_next     = state;
        fpc_next       = fpc;
        imem_req_next  = imem_req;
        imem_addr_next = imem_addr;

        unique case (state)
            ST_IDLE: begin
                if (redirect) begin
                    fpc_next = redirect_addr;
                end else if (count < FULL_COUNT) begin
                    imem_req_next  = 1'b1;
                    imem_addr_next = fpc;
                    fpc_next       = fpc + 32'd1;
                    state_next     = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redirect) begin
                    fpc_next = redirect_addr;
                    if (imem_ack) begin
                        imem_req_next = 1'b0;
                        state_next    = ST_IDLE;
                    end else begin
                        state_next    = ST_DROP;
                    end
                end else if (imem_ack) begin
                    if (count_next < FULL_COUNT) begin
                        imem_req_next  = 1'b1;
                        imem_addr_next = fpc;
                        fpc_next       = fpc + 32'd1;
                    end else begin
                        imem_req_next  = 1'b0;
                        state_next     = ST_IDLE;
                    end
                end
            end

            ST_DROP: begin
                if (redirect) begin
                    fpc_next = redirect_addr;
                end
                if (imem_ack) begin
                    imem_req_next = 1'b0;
                    state_next    = ST_IDLE;
                end
            end

            default: begin
                imem_req_next = 1'b0;
                state_next    = ST_IDLE;
            end
        endcase
    end

    // Register the FSM state, the fetch pointer and the memory request.
    // imem_addr is held steady for as long as imem_req is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            fpc       <= RESET_ADDR;
            imem_req  <= 1'b0;
            imem_addr <= RESET_ADDR;
        end else begin
            state     <= state_next;
            fpc       <= fpc_next;
            imem_req  <= imem_req_next;
            imem_addr <= imem_addr_next;
        end
    end

    // Queue occupancy and pointers. A redirect empties the queue by setting
    // both pointers back to zero, so any stale entries become unreachable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_next;
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Queue storage. Each entry holds the word together with the address it
    // was fetched from. The storage is cleared on reset so the head reads as
    // zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else if (fifo_wr) begin
            data_q[wr_ptr] <= imem_rdata;
            addr_q[wr_ptr] <= imem_addr;
        end
    end

endmodule

// File: tb/tb_riscv_fetch.sv
// tb_riscv_fetch: scoreboard bench for riscv_fetch (DEPTH=4, RESET_ADDR=0).
// The memory model returns rdata = address + 32'h100 after a programmable
// number of wait cycles. Expected {addr, word} pairs are queued when stimulus
// is issued. A negedge monitor pops the queue on every accepted handshake.

module tb_riscv_fetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;

    int tests_run    = 0;
    int tests_failed = 0;
    int pop_cnt      = 0;
    int ack_cnt      = 0;
    int mem_wait     = 0;
    int wcnt         = 0;
    logic req_seen   = 1'b0;
    int p0;

    always #5 clk = ~clk;

    riscv_fetch #(
        .DEPTH(DEPTH),
        .RESET_ADDR(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .inst(inst),
        .inst_addr(inst_addr),
        .inst_ready(inst_ready),
        .redirect(redirect),
        .redirect_addr(redirect_addr)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkAtLeast(input string name, input int actual, input int minimum);
        tests_run++;
        if (actual < minimum) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected at least %0d", name, actual, minimum);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] raddr);
        inst_ready    = ready;
        redirect      = redir;
        redirect_addr = raddr;
    endtask

    // Advance to just after the next rising edge, once the memory model has
    // updated.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pushSeq(input logic [31:0] start, input int n);
        logic [31:0] a;
        exp_t x;
        a = start;
        for (int i = 0; i < n; i++) begin
            x.addr = a;
            x.data = a + 32'h100;
            expq.push_back(x);
            a = a + 32'd1;
        end
    endtask

    task automatic doReset(input logic ready, input int wait_cycles);
        rst = 1'b1;
        applyStimulus(ready, 1'b0, 32'h0);
        mem_wait = wait_cycles;
        expq.delete();
        tick();
        tick();
        checkOutput("rst_imem_req", {31'b0, imem_req}, 32'h0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0);
        checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("rst_inst", inst, 32'h0);
        checkOutput("rst_inst_addr", inst_addr, 32'h0);
        pop_cnt = 0;
        ack_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic doRedirect(input logic [31:0] addr);
        applyStimulus(inst_ready, 1'b1, addr);
        expq.delete();
        pushSeq(addr, 64);
        tick();
        applyStimulus(inst_ready, 1'b0, 32'h0);
    endtask

    task automatic waitReqAddr(input logic [31:0] addr, input int budget, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (imem_req && imem_addr == addr) begin
                found = 1'b1;
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("[TB] FAIL %s: got req=%0b addr=%h, expected request at %h", name, imem_req, imem_addr, addr);
        end
    endtask

    // Instruction memory model: acks a request once it has been held for
    // mem_wait cycles, and returns address + 32'h100.
    always @(posedge clk) begin
        #1;
        if (imem_req) begin
            if (imem_ack || !req_seen) begin
                wcnt = 0;
            end else begin
                wcnt = wcnt + 1;
            end
            req_seen = 1'b1;
        end else begin
            req_seen = 1'b0;
            wcnt     = 0;
        end
        imem_ack   = imem_req && (wcnt == mem_wait);
        imem_rdata = imem_addr + 32'h100;
    end

    // Monitor: every accepted handshake must match the head of the queue of
    // expected words.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_ack) begin
                ack_cnt++;
            end
            if (inst_valid && inst_ready && !redirect) begin
                pop_cnt++;
                if (expq.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_pop: got addr %h, expected no handshake", inst_addr);
                end else begin
                    mon_e = expq.pop_front();
                    checkOutput("sb_inst_addr", inst_addr, mon_e.addr);
                    checkOutput("sb_inst", inst, mon_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Zero-wait memory with an always-ready core: first request, fill
        // latency, then one word per cycle.
        doReset(1'b1, 0);
        pushSeq(32'h0, 64);
        tick();
        checkOutput("first_req", {31'b0, imem_req}, 32'h1);
        checkOutput("first_addr", imem_addr, 32'h0);
`ifdef RISCV_FETCH_BYPASS_EN
        checkOutput("ack_cycle_valid", {31'b0, inst_valid}, 32'h1);
        tick();
        checkOutput("next_cycle_valid", {31'b0, inst_valid}, 32'h1);
        checkOutput("next_cycle_addr", inst_addr, 32'h1);
`else
        checkOutput("ack_cycle_valid", {31'b0, inst_valid}, 32'h0);
        tick();
        checkOutput("next_cycle_valid", {31'b0, inst_valid}, 32'h1);
        checkOutput("next_cycle_addr", inst_addr, 32'h0);
`endif
        p0 = pop_cnt;
        repeat (8) tick();
        checkOutput("throughput", 32'(pop_cnt - p0), 32'd8);

        // Core stalled: exactly DEPTH acks, then the request drops.
        doReset(1'b0, 0);
        pushSeq(32'h0, 64);
        repeat (15) tick();
        checkOutput("stall_acks", 32'(ack_cnt), 32'(DEPTH));
        checkOutput("stall_req", {31'b0, imem_req}, 32'h0);
        checkOutput("stall_valid", {31'b0, inst_valid}, 32'h1);
        checkOutput("stall_head_addr", inst_addr, 32'h0);
        checkOutput("stall_head_inst", inst, 32'h100);
        applyStimulus(1'b1, 1'b0, 32'h0);
        repeat (12) tick();
        checkOutput("drain_pops", 32'(pop_cnt), 32'd12);

        // Slow memory, redirect while the request for address 2 is pending.
        doReset(1'b1, 2);
        pushSeq(32'h0, 64);
        waitReqAddr(32'h2, 40, "req_addr2");
        checkOutput("pending_no_ack", {31'b0, imem_ack}, 32'h0);
        doRedirect(32'h40);
        p0 = pop_cnt;
        waitReqAddr(32'h40, 20, "req_after_drop");
        repeat (20) tick();
        checkAtLeast("pops_after_redirect", pop_cnt - p0, 3);

        // Redirect in the same cycle as an ack and a pop, two words queued.
        doReset(1'b0, 0);
        pushSeq(32'h0, 64);
        waitReqAddr(32'h2, 20, "req_addr2_fast");
        checkOutput("redir_cycle_ack", {31'b0, imem_ack}, 32'h1);
        checkOutput("redir_cycle_valid", {31'b0, inst_valid}, 32'h1);
        applyStimulus(1'b1, 1'b1, 32'h80);
        expq.delete();
        pushSeq(32'h80, 64);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("post_redir_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("post_redir_req", {31'b0, imem_req}, 32'h0);
        tick();
        checkOutput("new_req", {31'b0, imem_req}, 32'h1);
        checkOutput("new_req_addr", imem_addr, 32'h80);
        p0 = pop_cnt;
        repeat (10) tick();
        checkAtLeast("pops_after_80", pop_cnt - p0, 8);

        // Address wrap across 32'hFFFFFFFF.
        mem_wait = 1;
        doRedirect(32'hFFFF_FFFF);
        p0 = pop_cnt;
        repeat (20) tick();
        checkAtLeast("pops_wrap", pop_cnt - p0, 4);

        applyStimulus(1'b0, 1'b0, 32'h0);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
